add_align: RTL and testbench
============================

ADD_ALIGN -- requirements
Module: add_align

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: in_valid  input  1  operand pair valid.
REQ-004 SHALL have: in_ready  output  1  aligner can accept a pair.
REQ-005 SHALL have: mant_a, mant_b  input  8 each  normalized mantissas (bit7 = leading one; 8'h00 = zero operand).
REQ-006 SHALL have: exp_a, exp_b  input  8 each  biased exponents.
REQ-007 SHALL have: sign_a, sign_b  input  1 each  operand signs.
REQ-008 SHALL have: out_valid  output  1  aligned pair valid.
REQ-009 SHALL have: out_ready  input  1  downstream adder accepts the pair.
REQ-010 SHALL have: mant_big, mant_small  output  11 each  {mantissa, guard, round, sticky}.
REQ-011 SHALL have: exp_o  output  8  common (larger) exponent, fed unchanged to the renormalizer's exp input.
REQ-012 SHALL have: sign_big, sign_small  output  1 each  signs following the swap.

Function
REQ-013 SHALL implement FSM states IDLE, CMP, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 IDLE: on in_valid&&in_ready SHALL register all operands and go to CMP; otherwise stay in IDLE.
REQ-015 CMP: SHALL swap operands when exp_b>exp_a, or when exp_b==exp_a and mant_b>mant_a, so that big >= small in magnitude.
REQ-016 CMP: SHALL load mant_big={big,3'b000}, mant_small={small,3'b000}, exp_o=larger exponent, and d=|exp_a-exp_b| (8-bit unsigned).
REQ-017 CMP: d==0 SHALL go to DONE; d>=11 SHALL set mant_small=11'h001 (11'h000 if small==0) and go to DONE; otherwise SHALL load the counter with d and go to SHIFT.
REQ-018 SHIFT: each cycle SHALL shift mant_small right one bit, OR the bit shifted out of bit0 into the new bit0 (sticky), and decrement the counter; on the cycle the counter reaches 0 it SHALL go to DONE.
REQ-019 Latency SHALL be N rising edges from the accepting edge to out_valid high: N=1 for d==0 or d>=11, N=1+d for 1<=d<=10.
REQ-020 DONE: all outputs SHALL hold stable while out_valid&&!out_ready; on out_valid&&out_ready SHALL return to IDLE (a new pair is accepted no earlier than the following edge).
REQ-021 in_valid SHALL be ignored outside IDLE; only one pair is in flight at a time.
REQ-022 Exponent values 8'h00 and 8'hFF SHALL receive no special handling.

Reset
REQ-023 rst_n low SHALL force state=IDLE, counter=0, and mant_big, mant_small, exp_o, sign_big, sign_small all 0, at any time, including mid-SHIFT or in DONE.
REQ-024 After release, in_ready SHALL be 1 and out_valid 0; a partially aligned pair SHALL be discarded.

Structure
REQ-025 Widths SHALL live in shared package add_pkg: MANT_W=8, EXP_W=8, GRS_W=3, ALIGN_W=11, plus the FSM state enum.
REQ-026 The one-bit sticky right shift SHALL be the sub-module shr_sticky (11-bit in, 11-bit out, combinational); the FSM and the registers stay in add_align.

Verification
REQ-027 a=(0x80,exp 0x10), b=(0xC0,exp 0x10) -> swap; mant_big=0x600, mant_small=0x400, exp_o=0x10; out_valid 1 edge after accept.
REQ-028 a=(0xFF,0x13), b=(0x81,0x10) -> mant_big=0x7F8, mant_small=0x081 (sticky set), exp_o=0x13; latency 4 edges.
REQ-029 a=(0x80,0x20), b=(0x80,0x01) -> d=31, mant_small=0x001, latency 1; repeat with mant_b=0x00 -> mant_small=0x000.
REQ-030 Complete the REQ-028 pair with out_ready held low 5 cycles -> outputs stable, in_ready 0, a second in_valid ignored; raise out_ready -> IDLE next edge.
REQ-031 Assert rst_n low during SHIFT of d=8 -> all outputs 0 immediately; after release the next pair aligns correctly.
REQ-032 Chain with the renormalizer: 1.0 (0x80,e) + 1.0 (0x80,e) summed to a 12-bit value -> renormalized result 0x80, exponent e+1.

Source files
------------

// File: rtl/add_pkg.sv
// add_pkg -- shared widths, FSM state type and helpers for the add_align
// mantissa aligner.
//   MANT_W  : width of a normalized mantissa (bit MANT_W-1 is the leading one)
//   EXP_W   : width of a biased exponent
//   GRS_W   : guard/round/sticky extension bits
//   ALIGN_W : width of an aligned mantissa {mantissa, guard, round, sticky}
//   CNT_W   : width of the shift counter (covers shift distances 1..10)
package add_pkg;

  localparam int MANT_W  = 8;
  localparam int EXP_W   = 8;
  localparam int GRS_W   = 3;
  localparam int ALIGN_W = MANT_W + GRS_W;
  localparam int CNT_W   = 4;

  // Shift distances at or above this value push every mantissa bit into sticky.
  localparam logic [EXP_W-1:0] FULL_SHIFT = 8'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } align_state_t;

  // Append zero guard/round/sticky bits below a mantissa.
  function automatic logic [ALIGN_W-1:0] grs_ext(input logic [MANT_W-1:0] m);
    grs_ext = {m, 3'b000};
  endfunction

endpackage

// File: rtl/shr_sticky.sv
// shr_sticky -- one-bit logical right shift of an aligned mantissa that keeps
// the sticky property: the bit falling out of bit0 is ORed into the new bit0,
// so once any nonzero bit has been shifted away, bit0 stays set.
//   din  : aligned mantissa {mantissa, guard, round, sticky}
//   dout : din shifted right by one with sticky folding
module shr_sticky
  import add_pkg::*;
(
  input  logic [ALIGN_W-1:0] din,
  output logic [ALIGN_W-1:0] dout
);

  // New bit0 is the old bit1 (shifted down) ORed with the old bit0 (shifted out).
  assign dout = {1'b0, din[ALIGN_W-1:2], din[1] | din[0]};

endmodule

// File: rtl/add_align.sv
// add_align -- exponent-difference mantissa aligner feeding a floating-point
// adder. Accepts one operand pair at a time, orders it by magnitude, and
// shifts the smaller mantissa right (one bit per cycle, with sticky) until the
// exponents match.
//   clk, rst_n            : clock (rising edge) and async active-low reset
//   in_valid / in_ready   : operand pair handshake (ready only in IDLE)
//   mant_a/b, exp_a/b,
//   sign_a/b              : operand fields; mantissa 8'h00 means zero
//   out_valid / out_ready : aligned pair handshake (valid only in DONE)
//   mant_big, mant_small  : aligned mantissas {mantissa, guard, round, sticky}
//   exp_o                 : larger (common) exponent
//   sign_big, sign_small  : signs after the magnitude swap
module add_align
  import add_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MANT_W-1:0]  mant_a,
  input  logic [MANT_W-1:0]  mant_b,
  input  logic [EXP_W-1:0]   exp_a,
  input  logic [EXP_W-1:0]   exp_b,
  input  logic               sign_a,
  input  logic               sign_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALIGN_W-1:0] mant_big,
  output logic [ALIGN_W-1:0] mant_small,
  output logic [EXP_W-1:0]   exp_o,
  output logic               sign_big,
  output logic               sign_small
);

  align_state_t state;
  logic [CNT_W-1:0]  cnt;

  // Captured operand pair
  logic [MANT_W-1:0] a_mant, b_mant;
  logic [EXP_W-1:0]  a_exp, b_exp;
  logic              a_sign, b_sign;

  // Magnitude-ordered view of the captured pair
  logic              swap;
  logic [MANT_W-1:0] big_m, small_m;
  logic [EXP_W-1:0]  big_e, small_e;
  logic              big_s, small_s;
  logic [EXP_W-1:0]  diff;

  logic [ALIGN_W-1:0] small_shifted;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Order the captured operands so that big >= small in magnitude.
  always_comb begin
    swap = 1'b0;
    if (b_exp > a_exp) begin
      swap = 1'b1;
    end else if ((b_exp == a_exp) && (b_mant > a_mant)) begin
      swap = 1'b1;
    end else begin
      swap = 1'b0;
    end

    if (swap) begin
      big_m   = b_mant;
      big_e   = b_exp;
      big_s   = b_sign;
      small_m = a_mant;
      small_e = a_exp;
      small_s = a_sign;
    end else begin
      big_m   = a_mant;
      big_e   = a_exp;
      big_s   = a_sign;
      small_m = b_mant;
      small_e = b_exp;
      small_s = b_sign;
    end

    // big_e >= small_e after ordering, so this is |exp_a - exp_b|.
    diff = big_e - small_e;
  end

  shr_sticky u_shr (
    .din  (mant_small),
    .dout (small_shifted)
  );

  // Aligner FSM together with the operand, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= {CNT_W{1'b0}};
      a_mant     <= 8'h00;
      b_mant     <= 8'h00;
      a_exp      <= 8'h00;
      b_exp      <= 8'h00;
      a_sign     <= 1'b0;
      b_sign     <= 1'b0;
      mant_big   <= 11'h000;
      mant_small <= 11'h000;
      exp_o      <= 8'h00;
      sign_big   <= 1'b0;
      sign_small <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_mant <= mant_a;
            b_mant <= mant_b;
            a_exp  <= exp_a;
            b_exp  <= exp_b;
            a_sign <= sign_a;
            b_sign <= sign_b;
            state  <= CMP;
          end else begin
            state  <= IDLE;
          end
        end

        CMP: begin
          mant_big   <= grs_ext(big_m);
          exp_o      <= big_e;
          sign_big   <= big_s;
          sign_small <= small_s;
          if (diff == 8'd0) begin
            mant_small <= grs_ext(small_m);
            state      <= DONE;
          end else if (diff >= FULL_SHIFT) begin
            // Every bit of the small mantissa lands in sticky.
            mant_small <= (small_m == 8'h00) ? 11'h000 : 11'h001;
            state      <= DONE;
          end else begin
            mant_small <= grs_ext(small_m);
            cnt        <= diff[CNT_W-1:0];
            state      <= SHIFT;
          end
        end

        SHIFT: begin
          mant_small <= small_shifted;
          cnt        <= cnt - 4'd1;
          // cnt == 0 never occurs here in normal operation; treat it as done.
          if (cnt <= 4'd1) begin
            state <= DONE;
          end else begin
            state <= SHIFT;
          end
        end

        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end else begin
            state <= DONE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_align.sv
module tb_add_align;
  import add_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         mant_a, mant_b, exp_a, exp_b;
  logic               sign_a, sign_b;
  logic               out_valid;
  logic               out_ready;
  logic [10:0]        mant_big, mant_small;
  logic [7:0]         exp_o;
  logic               sign_big, sign_small;

  int vectors = 0;
  int errors  = 0;

  add_align dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mant_a     (mant_a),
    .mant_b     (mant_b),
    .exp_a      (exp_a),
    .exp_b      (exp_b),
    .sign_a     (sign_a),
    .sign_b     (sign_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mant_big   (mant_big),
    .mant_small (mant_small),
    .exp_o      (exp_o),
    .sign_big   (sign_big),
    .sign_small (sign_small)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present a pair at #1 after an edge, accept it, and count edges to out_valid.
  task automatic send(input string tag,
                      input logic [7:0] ma, input logic [7:0] ea, input logic sa,
                      input logic [7:0] mb, input logic [7:0] eb, input logic sb,
                      input int exp_lat);
    int lat;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    mant_a = ma; exp_a = ea; sign_a = sa;
    mant_b = mb; exp_b = eb; sign_b = sb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
  endtask

  // Complete the handshake in DONE and check the return to IDLE.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".idle_rdy"}, {31'd0, in_ready}, 32'd1);
    chk({tag, ".idle_vld"}, {31'd0, out_valid}, 32'd0);
  endtask

  logic [10:0] hold_big, hold_small;
  logic [7:0]  hold_exp;
  logic [11:0] sum;
  logic [7:0]  norm_m;
  logic [7:0]  norm_e;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mant_a = 8'h00; mant_b = 8'h00; exp_a = 8'h00; exp_b = 8'h00;
    sign_a = 1'b0; sign_b = 1'b0;
    #12;
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.mant_big", {21'd0, mant_big}, 32'h000);
    chk("rst.exp_o", {24'd0, exp_o}, 32'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Equal exponents, b larger mantissa -> swap.
    send("swap", 8'h80, 8'h10, 1'b0, 8'hC0, 8'h10, 1'b1, 1);
    chk("swap.mant_big", {21'd0, mant_big}, 32'h600);
    chk("swap.mant_small", {21'd0, mant_small}, 32'h400);
    chk("swap.exp_o", {24'd0, exp_o}, 32'h10);
    chk("swap.sign_big", {31'd0, sign_big}, 32'd1);
    chk("swap.sign_small", {31'd0, sign_small}, 32'd0);
    drain("swap");

    // d=3 with sticky, then backpressure for 5 cycles.
    send("d3", 8'hFF, 8'h13, 1'b1, 8'h81, 8'h10, 1'b0, 4);
    chk("d3.mant_big", {21'd0, mant_big}, 32'h7F8);
    chk("d3.mant_small", {21'd0, mant_small}, 32'h081);
    chk("d3.exp_o", {24'd0, exp_o}, 32'h13);
    chk("d3.sign_big", {31'd0, sign_big}, 32'd1);
    hold_big = mant_big; hold_small = mant_small; hold_exp = exp_o;
    mant_a = 8'h90; exp_a = 8'h55; mant_b = 8'hA0; exp_b = 8'h50;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold.out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold.in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold.mant_big", {21'd0, mant_big}, {21'd0, hold_big});
      chk("hold.mant_small", {21'd0, mant_small}, {21'd0, hold_small});
      chk("hold.exp_o", {24'd0, exp_o}, {24'd0, hold_exp});
    end
    in_valid = 1'b0;
    drain("hold");
    @(posedge clk); #1;
    chk("hold.still_idle", {31'd0, in_ready}, 32'd1);

    // d=31: everything into sticky; then zero small operand.
    send("d31", 8'h80, 8'h20, 1'b0, 8'h80, 8'h01, 1'b0, 1);
    chk("d31.mant_small", {21'd0, mant_small}, 32'h001);
    chk("d31.mant_big", {21'd0, mant_big}, 32'h400);
    chk("d31.exp_o", {24'd0, exp_o}, 32'h20);
    drain("d31");
    send("d31z", 8'h80, 8'h20, 1'b0, 8'h00, 8'h01, 1'b0, 1);
    chk("d31z.mant_small", {21'd0, mant_small}, 32'h000);
    drain("d31z");

    // Boundaries d=10 (last shifted case) and d=11 (first sticky-only case).
    send("d10", 8'h80, 8'h0A, 1'b0, 8'hFF, 8'h00, 1'b1, 11);
    chk("d10.mant_small", {21'd0, mant_small}, 32'h001);
    chk("d10.mant_big", {21'd0, mant_big}, 32'h400);
    chk("d10.sign_small", {31'd0, sign_small}, 32'd1);
    drain("d10");
    send("d11", 8'h80, 8'h0B, 1'b0, 8'h80, 8'h00, 1'b0, 1);
    chk("d11.mant_small", {21'd0, mant_small}, 32'h001);
    drain("d11");

    // Exponent 0xFF handled as an ordinary value, d=1.
    send("eff", 8'h90, 8'hFF, 1'b0, 8'h80, 8'hFE, 1'b0, 2);
    chk("eff.mant_big", {21'd0, mant_big}, 32'h480);
    chk("eff.mant_small", {21'd0, mant_small}, 32'h200);
    chk("eff.exp_o", {24'd0, exp_o}, 32'hFF);
    drain("eff");

    // Reset in the middle of a d=8 shift.
    mant_a = 8'h80; exp_a = 8'h18; mant_b = 8'h80; exp_b = 8'h10;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst.mant_big", {21'd0, mant_big}, 32'h000);
    chk("mrst.mant_small", {21'd0, mant_small}, 32'h000);
    chk("mrst.exp_o", {24'd0, exp_o}, 32'h00);
    chk("mrst.signs", {30'd0, sign_big, sign_small}, 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send("post", 8'hA0, 8'h12, 1'b0, 8'hF0, 8'h10, 1'b1, 3);
    chk("post.mant_big", {21'd0, mant_big}, 32'h500);
    chk("post.mant_small", {21'd0, mant_small}, 32'h1E0);
    chk("post.exp_o", {24'd0, exp_o}, 32'h12);
    drain("post");

    // 1.0 + 1.0: sum the aligned mantissas and renormalize.
    send("chain", 8'h80, 8'h40, 1'b0, 8'h80, 8'h40, 1'b0, 1);
    sum = {1'b0, mant_big} + {1'b0, mant_small};
    if (sum[11]) begin
      norm_m = sum[11:4];
      norm_e = exp_o + 8'd1;
    end else begin
      norm_m = sum[10:3];
      norm_e = exp_o;
    end
    chk("chain.mant", {24'd0, norm_m}, 32'h80);
    chk("chain.exp", {24'd0, norm_e}, 32'h41);
    drain("chain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
